vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Raster timing source for the display pipeline; runs on the pixel clock and produces DrawX/DrawY, blank and the sync strobes consumed by every sprite/background mapper downstream.
- Also produces frame-level pulses that game logic uses to schedule position and animation updates during vertical blanking.
- Default timing is 640x480 at 60 Hz, from a 25 MHz pixel rate.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- Derived constants: H_TOTAL = sum of the H terms (800), V_TOTAL = sum of the V terms (525). Both totals must be ≤ 1024.

Ports:
- vga_clk  in  1  pixel clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- pix_en  in  1  advance enable; tie to 1 when vga_clk is already the pixel rate
- DrawX  out  10  current horizontal position, 0..H_TOTAL-1
- DrawY  out  10  current vertical position, 0..V_TOTAL-1
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- blank  out  1  1 = visible region (display enable), 0 = blanked
- line_start  out  1  one-cycle pulse while DrawX==0
- frame_start  out  1  one-cycle pulse while DrawX==0 and DrawY==0
- vblank_start  out  1  one-cycle pulse while DrawX==0 and DrawY==V_VISIBLE
- frame_count  out  8  count of completed frames, wraps 255->0

Behaviour:
- One clock (vga_clk). Reset is asynchronous and active-low (reset_n).
- Every output is a register. Decode logic is computed from the next counter values, so all outputs in a given cycle describe the same (DrawX, DrawY).
- Reset values:
  - DrawX = H_TOTAL-1 (799), DrawY = V_TOTAL-1 (524).
  - hs = 1, vs = 1, blank = 0.
  - line_start = 0, frame_start = 0, vblank_start = 0, frame_count = 0.
- The first enabled edge after reset is released lands on (0,0) with frame_start = 1. No partial frame is emitted.
- Horizontal counter, when pix_en = 1: DrawX increments; at H_TOTAL-1 it wraps to 0.
- Vertical counter: increments only on the horizontal wrap; at V_TOTAL-1 (together with the horizontal wrap) it wraps to 0.
- pix_en = 0: every register holds, including the pulse outputs. A pulse therefore lasts exactly one enabled cycle, and stretches across any disabled cycles.
- blank = 1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
- hs = 0 iff H_VISIBLE+H_FP ≤ DrawX < H_VISIBLE+H_FP+H_SYNC, i.e. 656..751.
- vs = 0 iff V_VISIBLE+V_FP ≤ DrawY < V_VISIBLE+V_FP+V_SYNC, i.e. 490..491. vs asserts across entire lines.
- frame_count increments on the same edge on which frame_start rises, except for the first (0,0) after reset. So frame_count = 1 during the second frame.
- Latency: zero cycles between the counters and the decoded outputs. Downstream mappers that use a synchronous ROM add their own one-cycle pipeline.
- Reset asserted mid-frame: all outputs go immediately (asynchronously) to their reset values. After release, the next frame starts at (0,0).
- Widths: counters are 10-bit unsigned. Comparisons use 10-bit unsigned arithmetic with no overflow, since the totals are ≤ 1024.

Decomposition:
- Package vga_timing_pkg holds:
  - the default timing constants (H_/V_ visible, porches, sync);
  - the derived totals and sync start/end constants;
  - typedef coord_t (logic [9:0]).
- Sub-module vga_axis_counter: a wrap counter with an enable input and a terminal-count output. It is instantiated twice, for horizontal (enable = pix_en) and vertical (enable = pix_en & h terminal).
- Top level holds the decode registers, the pulse generators and frame_count.

Test Plan:
- Reset then release with pix_en = 1 -> first edge gives DrawX=0, DrawY=0, blank=1, frame_start=1, line_start=1, frame_count=0; edge 640 gives blank=0 with DrawX=640.
- Horizontal sync check -> hs falls at DrawX=656 and rises at DrawX=752; line_start pulses once per 800 cycles; DrawY increments on the 799->0 wrap.
- Full frame of 420000 cycles -> vs low exactly for DrawY 490..491 (1600 cycles); vblank_start once, at (0,480); next frame_start at cycle 420000 with frame_count=1.
- pix_en toggled 1,0,1,0 -> counters advance every other cycle; frame_start held high for 2 cycles at (0,0); frame period 840000 cycles.
- reset_n pulsed low at (300,200) -> outputs revert to 799/524, hs=1, vs=1, blank=0 without waiting for a clock edge; resume at (0,0) with frame_count=0.
- 256 frames -> frame_count wraps 255->0; blank high-count per frame = 307200.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 raster timing constants and coordinate type
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;

    localparam int H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_VISIBLE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: enabled 0..MAX wrap counter exposing its next value and terminal count
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int MAX = 799
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    output logic [9:0] o_count,
    output logic [9:0] o_next,
    output logic       o_tc
);

    localparam coord_t C_MAX = coord_t'(MAX);

    coord_t r_count;

    // Reset parks the counter on its terminal value so the first enabled edge wraps to 0
    assign o_tc    = r_count == C_MAX;
    assign o_next  = i_en ? (o_tc ? '0 : r_count + 10'd1) : r_count;
    assign o_count = r_count;

    // Advance to the precomputed next value
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_count <= C_MAX;
        else
            r_count <= o_next;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters with registered blank/sync decode and frame pulses
module vga_timing_gen #(
    parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int H_FP      = vga_timing_pkg::H_FP,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BP      = vga_timing_pkg::H_BP,
    parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int V_FP      = vga_timing_pkg::V_FP,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BP      = vga_timing_pkg::V_BP
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       pix_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       line_start,
    output logic       frame_start,
    output logic       vblank_start,
    output logic [7:0] frame_count
);

    import vga_timing_pkg::*;

    localparam int     L_H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int     L_V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam coord_t C_HV    = coord_t'(H_VISIBLE);
    localparam coord_t C_VV    = coord_t'(V_VISIBLE);
    localparam coord_t C_HSS   = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t C_HSE   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam coord_t C_VSS   = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t C_VSE   = coord_t'(V_VISIBLE + V_FP + V_SYNC);

    coord_t     w_x, w_y, w_nx, w_ny;
    logic       w_h_tc, w_v_tc;
    logic       r_hs, r_vs, r_blank, r_ls, r_fs, r_vbs, r_started;
    logic [7:0] r_fc;

    vga_axis_counter #(.MAX(L_H_TOT - 1)) u_h (
        .i_clk   (vga_clk),
        .i_rst_n (reset_n),
        .i_en    (pix_en),
        .o_count (w_x),
        .o_next  (w_nx),
        .o_tc    (w_h_tc)
    );

    vga_axis_counter #(.MAX(L_V_TOT - 1)) u_v (
        .i_clk   (vga_clk),
        .i_rst_n (reset_n),
        .i_en    (pix_en & w_h_tc),
        .o_count (w_y),
        .o_next  (w_ny),
        .o_tc    (w_v_tc)
    );

    // Decode from the next coordinates so every output lines up with the new DrawX/DrawY
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank   <= 1'b0;
            r_ls      <= 1'b0;
            r_fs      <= 1'b0;
            r_vbs     <= 1'b0;
            r_fc      <= '0;
            r_started <= 1'b0;
        end else if (pix_en) begin
            r_blank <= (w_nx < C_HV) && (w_ny < C_VV);
            r_hs    <= !((w_nx >= C_HSS) && (w_nx < C_HSE));
            r_vs    <= !((w_ny >= C_VSS) && (w_ny < C_VSE));
            r_ls    <= w_nx == '0;
            r_fs    <= (w_nx == '0) && (w_ny == '0);
            r_vbs   <= (w_nx == '0) && (w_ny == C_VV);
            if (w_h_tc && w_v_tc) begin
                r_started <= 1'b1;
                r_fc      <= r_fc + 8'(r_started);
            end
        end
    end

    assign DrawX        = w_x;
    assign DrawY        = w_y;
    assign hs           = r_hs;
    assign vs           = r_vs;
    assign blank        = r_blank;
    assign line_start   = r_ls;
    assign frame_start  = r_fs;
    assign vblank_start = r_vbs;
    assign frame_count  = r_fc;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of a shrunken raster (15x10 totals, 150-cycle frame)
module tb_vga_timing_gen;

    logic       vga_clk, reset_n, pix_en;
    logic [9:0] DrawX, DrawY;
    logic       hs, vs, blank, line_start, frame_start, vblank_start;
    logic [7:0] frame_count;
    int         n_checks = 0;
    int         n_fail   = 0;

    // H: 8 visible, fp 2, sync 3 (X 10..12), bp 2 -> 15; V: 6 visible, fp 1, sync 2 (Y 7..8), bp 1 -> 10
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut (
        .vga_clk      (vga_clk),
        .reset_n      (reset_n),
        .pix_en       (pix_en),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .hs           (hs),
        .vs           (vs),
        .blank        (blank),
        .line_start   (line_start),
        .frame_start  (frame_start),
        .vblank_start (vblank_start),
        .frame_count  (frame_count)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic test_reset;
        reset_n = 1'b1;
        pix_en  = 1'b0;
        #3 reset_n = 1'b0;
        repeat (3) @(negedge vga_clk);
        n_checks++; if (DrawX !== 10'd14) begin n_fail++; $display("FAIL reset DrawX: got %0d expected 14", DrawX); end
        n_checks++; if (DrawY !== 10'd9) begin n_fail++; $display("FAIL reset DrawY: got %0d expected 9", DrawY); end
        n_checks++; if (hs !== 1'b1) begin n_fail++; $display("FAIL reset hs: got %0b expected 1", hs); end
        n_checks++; if (vs !== 1'b1) begin n_fail++; $display("FAIL reset vs: got %0b expected 1", vs); end
        n_checks++; if (blank !== 1'b0) begin n_fail++; $display("FAIL reset blank: got %0b expected 0", blank); end
        n_checks++; if ({line_start, frame_start, vblank_start} !== 3'b000) begin n_fail++; $display("FAIL reset pulses: got %b expected 000", {line_start, frame_start, vblank_start}); end
        n_checks++; if (frame_count !== 8'd0) begin n_fail++; $display("FAIL reset frame_count: got %0d expected 0", frame_count); end
    endtask

    task automatic test_first_edge;
        reset_n = 1'b1;
        pix_en  = 1'b1;
        @(negedge vga_clk);
        n_checks++; if ({DrawX, DrawY} !== {10'd0, 10'd0}) begin n_fail++; $display("FAIL first_edge pos: got (%0d,%0d) expected (0,0)", DrawX, DrawY); end
        n_checks++; if (blank !== 1'b1) begin n_fail++; $display("FAIL first_edge blank: got %0b expected 1", blank); end
        n_checks++; if ({frame_start, line_start} !== 2'b11) begin n_fail++; $display("FAIL first_edge fs/ls: got %b expected 11", {frame_start, line_start}); end
        n_checks++; if (frame_count !== 8'd0) begin n_fail++; $display("FAIL first_edge frame_count: got %0d expected 0", frame_count); end
        repeat (8) @(negedge vga_clk);
        n_checks++; if (DrawX !== 10'd8) begin n_fail++; $display("FAIL edge8 DrawX: got %0d expected 8", DrawX); end
        n_checks++; if (blank !== 1'b0) begin n_fail++; $display("FAIL edge8 blank: got %0b expected 0", blank); end
        n_checks++; if (line_start !== 1'b0) begin n_fail++; $display("FAIL edge8 line_start: got %0b expected 0", line_start); end
    endtask

    task automatic test_hsync;
        int fall_x = -1, rise_x = -1, ls_cnt = 0, y_jumps = 0;
        logic p_hs;
        logic [9:0] p_y;
        for (int i = 0; i < 30; i++) begin
            p_hs = hs;
            p_y  = DrawY;
            @(negedge vga_clk);
            if (p_hs && !hs && fall_x < 0) fall_x = int'(DrawX);
            if (!p_hs && hs && rise_x < 0) rise_x = int'(DrawX);
            if (line_start) ls_cnt++;
            if (DrawY != p_y) begin
                y_jumps++;
                n_checks++; if (DrawX !== 10'd0 || DrawY !== p_y + 10'd1) begin n_fail++; $display("FAIL hsync y_step: got (%0d,%0d) expected (0,%0d)", DrawX, DrawY, p_y + 10'd1); end
            end
        end
        n_checks++; if (fall_x !== 10) begin n_fail++; $display("FAIL hsync fall_x: got %0d expected 10", fall_x); end
        n_checks++; if (rise_x !== 13) begin n_fail++; $display("FAIL hsync rise_x: got %0d expected 13", rise_x); end
        n_checks++; if (ls_cnt !== 2) begin n_fail++; $display("FAIL hsync line_start count: got %0d expected 2", ls_cnt); end
        n_checks++; if (y_jumps !== 2) begin n_fail++; $display("FAIL hsync y steps: got %0d expected 2", y_jumps); end
        n_checks++; if ({DrawX, DrawY} !== {10'd8, 10'd2}) begin n_fail++; $display("FAIL hsync end pos: got (%0d,%0d) expected (8,2)", DrawX, DrawY); end
    endtask

    task automatic test_vsync_frame;
        int cyc = 0, vbs_cnt = 0, vbs_x = -1, vbs_y = -1, vs_cnt = 0;
        while (!frame_start && cyc < 200) begin
            @(negedge vga_clk);
            cyc++;
            if (vblank_start) begin vbs_cnt++; vbs_x = int'(DrawX); vbs_y = int'(DrawY); end
            if (!vs) vs_cnt++;
        end
        n_checks++; if (cyc !== 112) begin n_fail++; $display("FAIL frame cycles to frame_start: got %0d expected 112", cyc); end
        n_checks++; if (frame_count !== 8'd1) begin n_fail++; $display("FAIL frame frame_count: got %0d expected 1", frame_count); end
        n_checks++; if (vbs_cnt !== 1) begin n_fail++; $display("FAIL frame vblank_start count: got %0d expected 1", vbs_cnt); end
        n_checks++; if (vbs_x !== 0 || vbs_y !== 6) begin n_fail++; $display("FAIL frame vblank_start pos: got (%0d,%0d) expected (0,6)", vbs_x, vbs_y); end
        n_checks++; if (vs_cnt !== 30) begin n_fail++; $display("FAIL frame vs low cycles: got %0d expected 30", vs_cnt); end
    endtask

    task automatic test_full_frame;
        int bl = 0, vl = 0, fs = 0;
        for (int i = 0; i < 150; i++) begin
            if (blank) bl++;
            if (!vs) vl++;
            if (frame_start) fs++;
            @(negedge vga_clk);
        end
        n_checks++; if (bl !== 48) begin n_fail++; $display("FAIL full_frame blank count: got %0d expected 48", bl); end
        n_checks++; if (vl !== 30) begin n_fail++; $display("FAIL full_frame vs count: got %0d expected 30", vl); end
        n_checks++; if (fs !== 1) begin n_fail++; $display("FAIL full_frame frame_start count: got %0d expected 1", fs); end
        n_checks++; if ({frame_start, frame_count} !== {1'b1, 8'd2}) begin n_fail++; $display("FAIL full_frame next start: got fs=%0b fc=%0d expected fs=1 fc=2", frame_start, frame_count); end
    endtask

    task automatic test_pix_en;
        int fs_cnt = 0;
        logic [9:0] x1 = '0, x2 = '0;
        for (int i = 0; i < 300; i++) begin
            pix_en = (i % 2) == 0;
            @(negedge vga_clk);
            if (frame_start) fs_cnt++;
            if (i == 1) x1 = DrawX;
            if (i == 2) x2 = DrawX;
        end
        n_checks++; if (x1 !== 10'd1) begin n_fail++; $display("FAIL pix_en hold DrawX: got %0d expected 1", x1); end
        n_checks++; if (x2 !== 10'd2) begin n_fail++; $display("FAIL pix_en advance DrawX: got %0d expected 2", x2); end
        n_checks++; if (fs_cnt !== 2) begin n_fail++; $display("FAIL pix_en frame_start cycles: got %0d expected 2", fs_cnt); end
        n_checks++; if ({DrawX, DrawY, frame_count} !== {10'd0, 10'd0, 8'd3}) begin n_fail++; $display("FAIL pix_en period: got (%0d,%0d) fc=%0d expected (0,0) fc=3", DrawX, DrawY, frame_count); end
        pix_en = 1'b1;
    endtask

    task automatic test_async_reset;
        repeat (33) @(negedge vga_clk);
        n_checks++; if ({DrawX, DrawY} !== {10'd3, 10'd2}) begin n_fail++; $display("FAIL async pre pos: got (%0d,%0d) expected (3,2)", DrawX, DrawY); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if ({DrawX, DrawY} !== {10'd14, 10'd9}) begin n_fail++; $display("FAIL async pos: got (%0d,%0d) expected (14,9)", DrawX, DrawY); end
        n_checks++; if ({hs, vs, blank} !== 3'b110) begin n_fail++; $display("FAIL async hs/vs/blank: got %b expected 110", {hs, vs, blank}); end
        n_checks++; if (frame_count !== 8'd0) begin n_fail++; $display("FAIL async frame_count: got %0d expected 0", frame_count); end
        @(negedge vga_clk);
        reset_n = 1'b1;
        @(negedge vga_clk);
        n_checks++; if ({DrawX, DrawY, frame_start, frame_count} !== {10'd0, 10'd0, 1'b1, 8'd0}) begin n_fail++; $display("FAIL async resume: got (%0d,%0d) fs=%0b fc=%0d expected (0,0) fs=1 fc=0", DrawX, DrawY, frame_start, frame_count); end
    endtask

    task automatic test_fc_wrap;
        repeat (255 * 150) @(negedge vga_clk);
        n_checks++; if ({frame_start, frame_count} !== {1'b1, 8'd255}) begin n_fail++; $display("FAIL wrap fc255: got fs=%0b fc=%0d expected fs=1 fc=255", frame_start, frame_count); end
        repeat (150) @(negedge vga_clk);
        n_checks++; if ({frame_start, frame_count} !== {1'b1, 8'd0}) begin n_fail++; $display("FAIL wrap fc0: got fs=%0b fc=%0d expected fs=1 fc=0", frame_start, frame_count); end
    endtask

    initial begin
        test_reset();
        test_first_edge();
        test_hsync();
        test_vsync_frame();
        test_full_frame();
        test_pix_en();
        test_async_reset();
        test_fc_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
